// File: rtl/store_write_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_write_buffer_pkg : load/store type codes and lane helpers      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package store_write_buffer_pkg;

    typedef enum logic [2:0] {
        LS_BYTE = 3'b000,
        LS_HALF = 3'b001,
        LS_WORD = 3'b011
    } ls_type_e;

    localparam int BE_W = 4;

    // True when a buffered entry supplies every byte the load asks for.
    function automatic logic be_covers(input logic [BE_W-1:0] entry_be,
                                       input logic [BE_W-1:0] load_be);
        return (entry_be & load_be) == load_be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_write_buffer_be_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_byte_enable_gen : replicates store data onto byte lanes and    |
// | derives byte enables plus the misaligned/invalid-type drop flag.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module store_byte_enable_gen
    import store_write_buffer_pkg::*;
(
    input  logic [2:0]      type_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [31:0]     data_i,
    output logic [31:0]     data_o,
    output logic [BE_W-1:0] be_o,
    output logic            drop_o
);

    always_comb begin
        data_o = '0;
        be_o   = '0;
        drop_o = 1'b1;
        case (type_i)
            LS_BYTE: begin
                data_o = {4{data_i[7:0]}};
                be_o   = 4'b0001 << addr_lo_i;
                drop_o = 1'b0;
            end
            LS_HALF: begin
                data_o = {2{data_i[15:0]}};
                be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                drop_o = addr_lo_i[0];
            end
            LS_WORD: begin
                data_o = data_i;
                be_o   = 4'b1111;
                drop_o = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_write_buffer : posted-write FIFO with load hazard check.        |
// | Macro STORE_BUF_FWD_EN enables forwarding from the youngest match.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_store_valid,
    input  logic [2:0]        i_store_type,
    input  logic [ADDR_W-1:0] i_store_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_store_ready,
    output logic              o_misaligned,
    input  logic              i_load_valid,
    input  logic [2:0]        i_load_type,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic              o_load_stall,
    output logic              o_load_fwd,
    output logic [31:0]       o_load_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [BE_W-1:0]   o_mem_be,
    input  logic              i_mem_ready,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    logic [31:0]     w_st_data;
    logic [BE_W-1:0] w_st_be;
    logic            w_st_drop;
    logic [31:0]     w_ld_lane_unused;
    logic [BE_W-1:0] w_ld_be;
    logic            w_ld_drop_unused;

    store_byte_enable_gen u_store_lanes (
        .type_i    (i_store_type),
        .addr_lo_i (i_store_addr[1:0]),
        .data_i    (i_store_data),
        .data_o    (w_st_data),
        .be_o      (w_st_be),
        .drop_o    (w_st_drop)
    );

    store_byte_enable_gen u_load_be (
        .type_i    (i_load_type),
        .addr_lo_i (i_load_addr[1:0]),
        .data_i    (32'h0),
        .data_o    (w_ld_lane_unused),
        .be_o      (w_ld_be),
        .drop_o    (w_ld_drop_unused)
    );

    logic [WA_W-1:0]  waddr_q [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [BE_W-1:0]  be_q    [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misaligned_q, misaligned_d;

    logic w_full, w_empty, w_push, w_pop;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_push  = i_store_valid & ~w_full & ~w_st_drop;
    assign w_pop   = ~w_empty & i_mem_ready;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        valid_d      = valid_q;
        misaligned_d = i_store_valid & w_st_drop;
        if (w_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (w_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Payload storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            waddr_q[wr_ptr_q] <= i_store_addr[ADDR_W-1:2];
            data_q[wr_ptr_q]  <= w_st_data;
            be_q[wr_ptr_q]    <= w_st_be;
        end
    end

    assign o_store_ready = ~w_full;
    assign o_empty       = w_empty;
    assign o_misaligned  = misaligned_q;
    assign o_mem_we      = ~w_empty;
    assign o_mem_addr    = w_empty ? '0 : {waddr_q[rd_ptr_q], 2'b00};
    assign o_mem_wdata   = w_empty ? '0 : data_q[rd_ptr_q];
    assign o_mem_be      = w_empty ? '0 : be_q[rd_ptr_q];

    logic [DEPTH-1:0] w_match;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_match[g] = i_load_valid & valid_q[g] &
                            (waddr_q[g] == i_load_addr[ADDR_W-1:2]);
    end

`ifdef STORE_BUF_FWD_EN
    logic [PTR_W-1:0] w_sel;
    logic             w_hit, w_cover;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_sel = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[rd_ptr_q + PTR_W'(k)]) begin
                w_sel = rd_ptr_q + PTR_W'(k);
            end
        end
    end

    assign w_hit        = |w_match;
    assign w_cover      = be_covers(be_q[w_sel], w_ld_be);
    assign o_load_fwd   = w_hit & w_cover;
    assign o_load_stall = w_hit & ~w_cover;
    assign o_load_data  = (w_hit & w_cover) ? data_q[w_sel] : '0;
`else
    logic w_ld_be_unused;

    assign w_ld_be_unused = ^w_ld_be;
    assign o_load_stall   = |w_match;
    assign o_load_fwd     = 1'b0;
    assign o_load_data    = '0;
`endif

endmodule
`default_nettype wire
